exc_vector_fetch: RTL and testbench

- Exception-entry sequencer for the multicycle CPU. It sits directly upstream of the memory-address mux and drives that mux's 3-bit select.
- When an exception is flagged, it saves EPC and forces the vector address (253/254/255). It then waits out memory latency and loads PC with the zero-extended vector byte.
- Outside an exception it passes the control unit's select through unchanged.

---
 rtl/exc_vector_fetch.sv | 167 ++++++++++++++++
 tb/tb_exc_vector_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_fetch.sv
// ---------------------------------------------------------------------------
// ExcVectorFetch (module exc_vector_fetch)
//
// Exception-entry sequencer for the multicycle CPU. It sits directly in
// front of the memory-address mux and owns that mux's select.
//
// When an exception flag is seen in IDLE, the block does four things:
//   - latches the cause;
//   - captures EPC (pc_in minus PC_DEC);
//   - points memory at the cause's vector byte (253/254/255);
//   - waits out the memory latency and loads PC with the zero-extended byte.
// Outside an exception the control unit's select passes straight through.
//
// Parameters:
//   MEM_LAT      memory read latency in cycles (>= 1); number of FETCH cycles
//   PC_DEC       amount subtracted from the already-incremented pc_in
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   exc_opcode   invalid-opcode flag (highest priority)
//   exc_overflow ALU overflow flag
//   exc_div0     divide-by-zero flag (lowest priority)
//   sel_in       memory-address select from the control unit
//   pc_in        current PC register value
//   mem_data_in  memory read data (low byte is the vector target)
//   mem_addr_sel select to the memory-address mux
//   epc_out      EPC value to write
//   epc_write    EPC register write enable (one cycle, in SAVE)
//   pc_out       new PC value (non-zero only in LOAD)
//   pc_write     PC write enable (one cycle, in LOAD)
//   exc_cause    latched cause: 0 none, 1 opcode, 2 overflow, 3 div0
//   busy         high while a sequence is active; control unit must stall
// ---------------------------------------------------------------------------
module exc_vector_fetch #(
  parameter int MEM_LAT = 1,
  parameter int PC_DEC  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [2:0]  sel_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_addr_sel,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic [1:0]  exc_cause,
  output logic        busy
);

  // The counter must hold MEM_LAT-1; keep at least one bit for MEM_LAT=1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    FETCH = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     epc_q, epc_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      vec_sel;

  // Only the vector byte is used; the upper data bits are intentionally dropped.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data_in[31:8];

  // State, EPC, cause and FETCH counter registers. Reset clears EPC and cause,
  // so a reset in the middle of a sequence leaves no partial exception state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      epc_q   <= 32'd0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mux select for the vector byte of the latched cause:
  // select 2/3/4 addresses bytes 253/254/255.
  always_comb begin
    vec_sel = 3'd0;
    unique case (cause_q)
      2'd1:    vec_sel = 3'd2;
      2'd2:    vec_sel = 3'd3;
      2'd3:    vec_sel = 3'd4;
      default: vec_sel = 3'd0;
    endcase
  end

  // Next-state and output logic. While busy, sel_in and all exception flags
  // are ignored; a flag still high on return to IDLE starts a fresh sequence.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    mem_addr_sel = sel_in;
    epc_write    = 1'b0;
    pc_write     = 1'b0;
    pc_out       = 32'd0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exc_opcode || exc_overflow || exc_div0) begin
          state_d = SAVE;
          epc_d   = pc_in - 32'(PC_DEC);
          if (exc_opcode) begin
            cause_d = 2'd1;
          end else if (exc_overflow) begin
            cause_d = 2'd2;
          end else begin
            cause_d = 2'd3;
          end
        end
      end

      SAVE: begin
        busy         = 1'b1;
        epc_write    = 1'b1;
        mem_addr_sel = vec_sel;
        cnt_d        = CW'(MEM_LAT - 1);
        state_d      = FETCH;
      end

      // The counter is loaded with MEM_LAT-1 and leaves at zero,
      // so FETCH lasts exactly MEM_LAT cycles.
      FETCH: begin
        busy         = 1'b1;
        mem_addr_sel = vec_sel;
        if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      LOAD: begin
        busy         = 1'b1;
        mem_addr_sel = vec_sel;
        pc_out       = {24'd0, mem_data_in[7:0]};
        pc_write     = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign epc_out   = epc_q;
  assign exc_cause = cause_q;

endmodule

// File: tb/tb_exc_vector_fetch.sv
// ---------------------------------------------------------------------------
// Self-checking bench for exc_vector_fetch.
//
// Two instances run side by side: one with MEM_LAT=1 and one with MEM_LAT=3.
// They share clock, reset, sel_in, pc_in and mem_data_in. Each instance has
// its own exception flags, so only the instance under test is disturbed.
// Expected per-cycle outputs are written out as constants taken from the
// sequence timing.
// ---------------------------------------------------------------------------
module tb_exc_vector_fetch;

  typedef struct packed {
    logic [2:0]  sel;
    logic        busy;
    logic        epcw;
    logic [31:0] epc;
    logic        pcw;
    logic [31:0] pc;
    logic [1:0]  cause;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  flags1, flags3;
  logic [2:0]  selIn;
  logic [31:0] pcIn;
  logic [31:0] memData;

  logic [2:0]  sel1, sel3;
  logic [31:0] epc1, epc3, pcOut1, pcOut3;
  logic        epcw1, epcw3, pcw1, pcw3, busy1, busy3;
  logic [1:0]  cause1, cause3;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  exc_vector_fetch #(.MEM_LAT(1), .PC_DEC(4)) dut1 (
    .clk(clk), .reset(reset),
    .exc_opcode(flags1[2]), .exc_overflow(flags1[1]), .exc_div0(flags1[0]),
    .sel_in(selIn), .pc_in(pcIn), .mem_data_in(memData),
    .mem_addr_sel(sel1), .epc_out(epc1), .epc_write(epcw1),
    .pc_out(pcOut1), .pc_write(pcw1), .exc_cause(cause1), .busy(busy1)
  );

  exc_vector_fetch #(.MEM_LAT(3), .PC_DEC(4)) dut3 (
    .clk(clk), .reset(reset),
    .exc_opcode(flags3[2]), .exc_overflow(flags3[1]), .exc_div0(flags3[0]),
    .sel_in(selIn), .pc_in(pcIn), .mem_data_in(memData),
    .mem_addr_sel(sel3), .epc_out(epc3), .epc_write(epcw3),
    .pc_out(pcOut3), .pc_write(pcw3), .exc_cause(cause3), .busy(busy3)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] sel, input logic busy, input logic epcw,
                              input logic [31:0] epc, input logic pcw, input logic [31:0] pc,
                              input logic [1:0] cause);
    exp_t e;
    e.sel = sel; e.busy = busy; e.epcw = epcw; e.epc = epc;
    e.pcw = pcw; e.pc = pc; e.cause = cause;
    return e;
  endfunction

  // Drive one cycle of inputs (flags to instance d only), push the expected
  // outputs, and compare against the DUT at the falling edge.
  // Control returns just after the next rising edge.
  task automatic applyStimulus(input string tag, input int d, input logic rst,
                               input logic [2:0] flags, input logic [2:0] sel,
                               input logic [31:0] pc, input logic [31:0] md, input exp_t e);
    exp_t got;
    reset   = rst;
    flags1  = (d == 1) ? flags : 3'b000;
    flags3  = (d == 3) ? flags : 3'b000;
    selIn   = sel;
    pcIn    = pc;
    memData = md;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    if (d == 1) begin
      checkOutput({tag, ".sel"},   32'(sel1),   32'(got.sel));
      checkOutput({tag, ".busy"},  32'(busy1),  32'(got.busy));
      checkOutput({tag, ".epcw"},  32'(epcw1),  32'(got.epcw));
      checkOutput({tag, ".epc"},   epc1,        got.epc);
      checkOutput({tag, ".pcw"},   32'(pcw1),   32'(got.pcw));
      checkOutput({tag, ".pc"},    pcOut1,      got.pc);
      checkOutput({tag, ".cause"}, 32'(cause1), 32'(got.cause));
    end else begin
      checkOutput({tag, ".sel"},   32'(sel3),   32'(got.sel));
      checkOutput({tag, ".busy"},  32'(busy3),  32'(got.busy));
      checkOutput({tag, ".epcw"},  32'(epcw3),  32'(got.epcw));
      checkOutput({tag, ".epc"},   epc3,        got.epc);
      checkOutput({tag, ".pcw"},   32'(pcw3),   32'(got.pcw));
      checkOutput({tag, ".pc"},    pcOut3,      got.pc);
      checkOutput({tag, ".cause"}, 32'(cause3), 32'(got.cause));
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] F_OPC = 3'b100;
  localparam logic [2:0] F_OVF = 3'b010;
  localparam logic [2:0] F_DIV = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  initial begin
    reset = 1'b1; flags1 = '0; flags3 = '0; selIn = '0; pcIn = '0; memData = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state: while reset is held, both instances are idle with pass-through select.
    applyStimulus("rst1", 1, 1'b1, F_NONE, 3'd5, 32'h40, 32'h0, mk(3'd5, 0, 0, 32'h0, 0, 32'h0, 2'd0));
    applyStimulus("rst3", 3, 1'b1, F_NONE, 3'd6, 32'h40, 32'h0, mk(3'd6, 0, 0, 32'h0, 0, 32'h0, 2'd0));

    // Idle pass-through of sel_in 0..6.
    for (int i = 0; i <= 6; i++) begin
      applyStimulus($sformatf("idle%0d", i), 1, 1'b0, F_NONE, 3'(i), 32'h1234, 32'hFF,
                    mk(3'(i), 0, 0, 32'h0, 0, 32'h0, 2'd0));
    end

    // MEM_LAT=1 opcode exception: sel_in changes while busy must be ignored.
    applyStimulus("op.c0", 1, 0, F_OPC,  3'd5, 32'h40, 32'h0,  mk(3'd5, 0, 0, 32'h0,  0, 32'h0,  2'd0));
    applyStimulus("op.c1", 1, 0, F_NONE, 3'd0, 32'h40, 32'h0,  mk(3'd2, 1, 1, 32'h3C, 0, 32'h0,  2'd1));
    applyStimulus("op.c2", 1, 0, F_NONE, 3'd1, 32'h40, 32'hA5, mk(3'd2, 1, 0, 32'h3C, 0, 32'h0,  2'd1));
    applyStimulus("op.c3", 1, 0, F_NONE, 3'd1, 32'h40, 32'hA5, mk(3'd2, 1, 0, 32'h3C, 1, 32'hA5, 2'd1));
    applyStimulus("op.c4", 1, 0, F_NONE, 3'd6, 32'h40, 32'hA5, mk(3'd6, 0, 0, 32'h3C, 0, 32'h0,  2'd1));

    // MEM_LAT=3: overflow and div0 together, so overflow wins.
    // The vector select is held for 5 cycles and pc_write appears in cycle 5 only.
    applyStimulus("ov.c0", 3, 0, F_OVF | F_DIV, 3'd1, 32'h100, 32'h12345677, mk(3'd1, 0, 0, 32'h0,  0, 32'h0,  2'd0));
    applyStimulus("ov.c1", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd3, 1, 1, 32'hFC, 0, 32'h0,  2'd2));
    applyStimulus("ov.c2", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd3, 1, 0, 32'hFC, 0, 32'h0,  2'd2));
    applyStimulus("ov.c3", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd3, 1, 0, 32'hFC, 0, 32'h0,  2'd2));
    applyStimulus("ov.c4", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd3, 1, 0, 32'hFC, 0, 32'h0,  2'd2));
    applyStimulus("ov.c5", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd3, 1, 0, 32'hFC, 1, 32'h77, 2'd2));
    applyStimulus("ov.c6", 3, 0, F_NONE, 3'd1, 32'h100, 32'h12345677, mk(3'd1, 0, 0, 32'hFC, 0, 32'h0,  2'd2));

    // div0 raised during FETCH and still high in IDLE.
    // The second sequence runs with cause 3; mem_data_in 0xFFFFFF80 gives pc_out 0x80.
    applyStimulus("dh.c0", 1, 0, F_OPC,  3'd0, 32'h200, 32'h0,        mk(3'd0, 0, 0, 32'h3C,  0, 32'h0,  2'd1));
    applyStimulus("dh.c1", 1, 0, F_NONE, 3'd0, 32'h200, 32'h0,        mk(3'd2, 1, 1, 32'h1FC, 0, 32'h0,  2'd1));
    applyStimulus("dh.c2", 1, 0, F_DIV,  3'd0, 32'h200, 32'h10,       mk(3'd2, 1, 0, 32'h1FC, 0, 32'h0,  2'd1));
    applyStimulus("dh.c3", 1, 0, F_DIV,  3'd0, 32'h200, 32'h10,       mk(3'd2, 1, 0, 32'h1FC, 1, 32'h10, 2'd1));
    applyStimulus("dh.c4", 1, 0, F_DIV,  3'd1, 32'h300, 32'h0,        mk(3'd1, 0, 0, 32'h1FC, 0, 32'h0,  2'd1));
    applyStimulus("dh.c5", 1, 0, F_NONE, 3'd1, 32'h300, 32'h0,        mk(3'd4, 1, 1, 32'h2FC, 0, 32'h0,  2'd3));
    applyStimulus("dh.c6", 1, 0, F_NONE, 3'd1, 32'h300, 32'hFFFFFF80, mk(3'd4, 1, 0, 32'h2FC, 0, 32'h0,  2'd3));
    applyStimulus("dh.c7", 1, 0, F_NONE, 3'd1, 32'h300, 32'hFFFFFF80, mk(3'd4, 1, 0, 32'h2FC, 1, 32'h80, 2'd3));
    applyStimulus("dh.c8", 1, 0, F_NONE, 3'd2, 32'h300, 32'h0,        mk(3'd2, 0, 0, 32'h2FC, 0, 32'h0,  2'd3));

    // div0 raised during FETCH but low again by IDLE: no second sequence.
    applyStimulus("dl.c0", 1, 0, F_OPC,  3'd0, 32'h400, 32'h0, mk(3'd0, 0, 0, 32'h2FC, 0, 32'h0, 2'd3));
    applyStimulus("dl.c1", 1, 0, F_NONE, 3'd0, 32'h400, 32'h0, mk(3'd2, 1, 1, 32'h3FC, 0, 32'h0, 2'd1));
    applyStimulus("dl.c2", 1, 0, F_DIV,  3'd0, 32'h400, 32'h0, mk(3'd2, 1, 0, 32'h3FC, 0, 32'h0, 2'd1));
    applyStimulus("dl.c3", 1, 0, F_NONE, 3'd0, 32'h400, 32'h0, mk(3'd2, 1, 0, 32'h3FC, 1, 32'h0, 2'd1));
    applyStimulus("dl.c4", 1, 0, F_NONE, 3'd3, 32'h400, 32'h0, mk(3'd3, 0, 0, 32'h3FC, 0, 32'h0, 2'd1));
    applyStimulus("dl.c5", 1, 0, F_NONE, 3'd0, 32'h400, 32'h0, mk(3'd0, 0, 0, 32'h3FC, 0, 32'h0, 2'd1));

    // MEM_LAT=3: reset asserted in the second FETCH cycle aborts the sequence.
    // The instance returns to IDLE with EPC and cause cleared, and pc_write never pulses.
    applyStimulus("rf.c0", 3, 0, F_DIV,  3'd0, 32'h500, 32'h55, mk(3'd0, 0, 0, 32'hFC,  0, 32'h0, 2'd2));
    applyStimulus("rf.c1", 3, 0, F_NONE, 3'd0, 32'h500, 32'h55, mk(3'd4, 1, 1, 32'h4FC, 0, 32'h0, 2'd3));
    applyStimulus("rf.c2", 3, 0, F_NONE, 3'd0, 32'h500, 32'h55, mk(3'd4, 1, 0, 32'h4FC, 0, 32'h0, 2'd3));
    applyStimulus("rf.c3", 3, 1, F_NONE, 3'd0, 32'h500, 32'h55, mk(3'd4, 1, 0, 32'h4FC, 0, 32'h0, 2'd3));
    applyStimulus("rf.c4", 3, 0, F_NONE, 3'd5, 32'h500, 32'h55, mk(3'd5, 0, 0, 32'h0,   0, 32'h0, 2'd0));
    applyStimulus("rf.c5", 3, 0, F_NONE, 3'd5, 32'h500, 32'h55, mk(3'd5, 0, 0, 32'h0,   0, 32'h0, 2'd0));
    applyStimulus("rf.c6", 3, 0, F_NONE, 3'd2, 32'h500, 32'h55, mk(3'd2, 0, 0, 32'h0,   0, 32'h0, 2'd0));

    // pc_in=0 wraps EPC to 0xFFFFFFFC.
    // The instance was cleared by the shared reset above.
    applyStimulus("wr.c0", 1, 0, F_OVF,  3'd0, 32'h0, 32'h0,        mk(3'd0, 0, 0, 32'h0,        0, 32'h0,  2'd0));
    applyStimulus("wr.c1", 1, 0, F_NONE, 3'd0, 32'h0, 32'h0,        mk(3'd3, 1, 1, 32'hFFFFFFFC, 0, 32'h0,  2'd2));
    applyStimulus("wr.c2", 1, 0, F_NONE, 3'd0, 32'h0, 32'hFFFFFF80, mk(3'd3, 1, 0, 32'hFFFFFFFC, 0, 32'h0,  2'd2));
    applyStimulus("wr.c3", 1, 0, F_NONE, 3'd0, 32'h0, 32'hFFFFFF80, mk(3'd3, 1, 0, 32'hFFFFFFFC, 1, 32'h80, 2'd2));
    applyStimulus("wr.c4", 1, 0, F_NONE, 3'd4, 32'h0, 32'hFFFFFF80, mk(3'd4, 0, 0, 32'hFFFFFFFC, 0, 32'h0,  2'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
